// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait handling with a timeout, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        exmem_Branch,
  input  logic        exmem_ZERO,
  input  logic        exmem_MemRead,
  input  logic        exmem_MemWrite,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush,
  output logic        pc_sel,
  output logic        exmem_hold,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [15:0] stall_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        memErr_q, memErr_d;
  logic [15:0] stallCnt_q, stallCnt_d;

  logic memOp;
  logic taken;
  logic loadUse;

  assign memOp   = exmem_MemRead | exmem_MemWrite;
  assign taken   = exmem_Branch & exmem_ZERO;
  assign loadUse = idex_MemRead && (idex_rd != 5'd0) &&
                   ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      waitCnt_q  <= 8'd0;
      memErr_q   <= 1'b0;
      stallCnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // Priority inside RUN: memory hold, then branch flush, then load-use stall.
  // Outputs are forced to the idle pattern while reset is held.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    memErr_d    = memErr_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    pc_sel      = 1'b0;
    exmem_hold  = 1'b0;
    dmem_req    = 1'b0;

    if (!reset) begin
      unique case (state_q)
        RUN: begin
          dmem_req = memOp;
          if (memOp && !dmem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            waitCnt_d  = 8'd0;
            state_d    = MEM_WAIT;
          end else if (taken) begin
            flush       = 1'b1;
            pc_sel      = 1'b1;
            idex_bubble = 1'b1;
          end else if (loadUse) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end

        MEM_WAIT: begin
          dmem_req   = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          exmem_hold = 1'b1;
          if (dmem_ready) begin
            waitCnt_d = 8'd0;
            state_d   = RUN;
          end else if (waitCnt_q == WAIT_LAST) begin
            memErr_d  = 1'b1;
            waitCnt_d = 8'd0;
            state_d   = RUN;
          end else begin
            waitCnt_d = waitCnt_q + 8'd1;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (!pc_write && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  assign mem_err     = memErr_q;
  assign stall_count = stallCnt_q;

endmodule
